// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
//   Periodically scans a masked set of ADC channels through an external SPI
//   ADC master. It stores each conversion result in a per-channel table and
//   reports overruns and conversion timeouts through sticky error flags.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable_i          runs the period timer and allows scans to start
//   chan_mask_i       channels to include in a scan (sampled at scan start)
//   period_i          scan interval in clk cycles (0/1 -> every cycle)
//   clear_err_i       pulse; clears the sticky error flags
//   start_cnv_o       one-cycle conversion request to the SPI master
//   channel_o         channel select, stable for the whole conversion
//   cnv_complete_i    conversion done level from the SPI master
//   result_i          conversion data, valid while cnv_complete_i is high
//   rd_chan_i         result table read address
//   rd_data_o         combinational table read
//   sample_valid_o    pulse; sample_chan_o/sample_data_o hold a new sample
//   scan_done_o       pulse at the end of each scan
//   busy_o            FSM not idle
//   overrun_err_o     sticky; a period tick arrived while busy
//   timeout_err_o     sticky; a conversion exceeded TIMEOUT cycles
module adc_scan_sequencer #(
  parameter int NUM_CH  = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] chan_mask_i,
  input  logic [15:0]       period_i,
  input  logic              clear_err_i,
  output logic              start_cnv_o,
  output logic [2:0]        channel_o,
  input  logic              cnv_complete_i,
  input  logic [11:0]       result_i,
  input  logic [2:0]        rd_chan_i,
  output logic [11:0]       rd_data_o,
  output logic              sample_valid_o,
  output logic [2:0]        sample_chan_o,
  output logic [11:0]       sample_data_o,
  output logic              scan_done_o,
  output logic              busy_o,
  output logic              overrun_err_o,
  output logic              timeout_err_o
);

  localparam logic [11:0] TMO = 12'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_CLR, S_WAIT_DONE, S_STORE, S_NEXT
  } state_e;

  state_e                      state_q;
  logic [15:0]                 tmr_q, tmr_d;
  logic                        tick;
  logic [11:0]                 wait_q;
  logic [NUM_CH-1:0]           scan_mask_q, rem_mask;
  logic [NUM_CH-1:0][11:0]     table_q;
  logic                        start_cnv_q, sample_valid_q, scan_done_q;
  logic [2:0]                  channel_q, sample_chan_q;
  logic [11:0]                 sample_data_q;
  logic                        overrun_q, timeout_q;
  logic                        ovr_set, tmo_set;

  // Lowest set bit; scanning always clears lower bits first, so this also
  // yields the next higher channel of a partially consumed mask.
  function automatic logic [2:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) idx = 3'(i);
    return idx;
  endfunction

  // Period timer: counts 0..period-1, ticks on the last count, holds at 0
  // while disabled.
  always_comb begin
    tick  = enable_i && ((period_i <= 16'd1) || (tmr_q == period_i - 16'd1));
    tmr_d = (!enable_i || tick) ? 16'd0 : tmr_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  always_comb begin
    rem_mask = scan_mask_q & ~(NUM_CH'(1) << channel_q);
    ovr_set  = tick && (state_q != S_IDLE);
    tmo_set  = (state_q == S_WAIT_DONE) && !cnv_complete_i && (wait_q == TMO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      wait_q         <= '0;
      scan_mask_q    <= '0;
      table_q        <= '0;
      start_cnv_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      scan_done_q    <= 1'b0;
      channel_q      <= '0;
      sample_chan_q  <= '0;
      sample_data_q  <= '0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      start_cnv_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      scan_done_q    <= 1'b0;
      // A new error event takes priority over a coincident clear.
      overrun_q      <= ovr_set | (overrun_q & ~clear_err_i);
      timeout_q      <= tmo_set | (timeout_q & ~clear_err_i);

      case (state_q)
        S_IDLE: begin
          if (tick && (chan_mask_i != '0)) begin
            scan_mask_q <= chan_mask_i;
            channel_q   <= lowest_ch(chan_mask_i);
            start_cnv_q <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          wait_q  <= '0;
          state_q <= S_WAIT_CLR;
        end
        // cnv_complete may still be high from the previous conversion here.
        S_WAIT_CLR: state_q <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (cnv_complete_i) begin
            table_q[channel_q] <= result_i;
            sample_chan_q      <= channel_q;
            sample_data_q      <= result_i;
            sample_valid_q     <= 1'b1;
            state_q            <= S_STORE;
          end else if (wait_q == TMO) begin
            scan_mask_q <= rem_mask;
            scan_done_q <= (rem_mask == '0) || !enable_i;
            state_q     <= S_NEXT;
          end else begin
            wait_q <= wait_q + 12'd1;
          end
        end
        // The end-of-scan decision is made on the way into NEXT so that
        // scan_done is high during NEXT, one cycle after the final store.
        S_STORE: begin
          scan_mask_q <= rem_mask;
          scan_done_q <= (rem_mask == '0) || !enable_i;
          state_q     <= S_NEXT;
        end
        S_NEXT: begin
          if (scan_done_q) begin
            state_q <= S_IDLE;
          end else begin
            channel_q   <= lowest_ch(scan_mask_q);
            start_cnv_q <= 1'b1;
            state_q     <= S_START;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_cnv_o    = start_cnv_q;
  assign channel_o      = channel_q;
  assign rd_data_o      = table_q[rd_chan_i];
  assign sample_valid_o = sample_valid_q;
  assign sample_chan_o  = sample_chan_q;
  assign sample_data_o  = sample_data_q;
  assign scan_done_o    = scan_done_q;
  assign busy_o         = (state_q != S_IDLE);
  assign overrun_err_o  = overrun_q;
  assign timeout_err_o  = timeout_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Testbench for adc_scan_sequencer: an ADC responder model plus event
// recorder, and one task per scenario checking against a reference built
// from the mask bits, ADC deliveries and the timer period.
module tb_adc_scan_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clear_err = 1'b0;
  logic        cnv_complete = 1'b0;
  logic [7:0]  chan_mask = '0;
  logic [15:0] period = '0;
  logic [11:0] result = '0;
  logic [2:0]  rd_chan = '0;
  logic        start_cnv, sample_valid, scan_done, busy, overrun_err, timeout_err;
  logic [2:0]  channel, sample_chan;
  logic [11:0] rd_data, sample_data;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int st_ch[$], st_cyc[$], sv_ch[$], sv_cyc[$], sd_cyc[$], rise_ch[$], rise_cyc[$];
  logic [11:0] sv_data[$], rise_data[$];
  logic [11:0] exp_tab [8];
  int adc_lat = 5, hang_ch = -1;
  bit adc_rand_lat = 0, adc_rand_data = 0;

  adc_scan_sequencer #(.NUM_CH(8), .TIMEOUT(4095)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .chan_mask_i(chan_mask),
    .period_i(period), .clear_err_i(clear_err), .start_cnv_o(start_cnv),
    .channel_o(channel), .cnv_complete_i(cnv_complete), .result_i(result),
    .rd_chan_i(rd_chan), .rd_data_o(rd_data), .sample_valid_o(sample_valid),
    .sample_chan_o(sample_chan), .sample_data_o(sample_data),
    .scan_done_o(scan_done), .busy_o(busy), .overrun_err_o(overrun_err),
    .timeout_err_o(timeout_err));

  always #5 clk = ~clk;

  // Event recorder and SPI ADC model: drops cnv_complete one cycle after
  // start_cnv, raises it with fresh data after the conversion latency.
  initial begin
    int cnt, cur_lat;
    logic [2:0] pch;
    cnt = -1; cur_lat = 1; pch = '0;
    foreach (exp_tab[i]) exp_tab[i] = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        cnt = -1; cnv_complete = 1'b0;
        foreach (exp_tab[i]) exp_tab[i] = '0;
      end else begin
        if (start_cnv) begin st_ch.push_back(int'(channel)); st_cyc.push_back(cyc); end
        if (sample_valid) begin
          sv_ch.push_back(int'(sample_chan)); sv_data.push_back(sample_data); sv_cyc.push_back(cyc);
        end
        if (scan_done) sd_cyc.push_back(cyc);
        if (start_cnv) begin
          pch = channel; cnt = 0;
          cur_lat = adc_rand_lat ? int'($urandom_range(1, 12)) : adc_lat;
        end else if (cnt >= 0) begin
          cnt++;
          if (cnt == 1) cnv_complete = 1'b0;
          if (cnt == 1 + cur_lat && int'(pch) != hang_ch) begin
            result = adc_rand_data ? 12'($urandom_range(0, 4095)) : 12'h100 + 12'(pch);
            cnv_complete = 1'b1;
            exp_tab[pch] = result;
            rise_ch.push_back(int'(pch)); rise_data.push_back(result); rise_cyc.push_back(cyc);
            cnt = -1;
          end
        end
      end
    end
  end

  task automatic clr_q();
    st_ch.delete(); st_cyc.delete(); sv_ch.delete(); sv_cyc.delete(); sv_data.delete();
    sd_cyc.delete(); rise_ch.delete(); rise_cyc.delete(); rise_data.delete();
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if (start_cnv !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b exp 0", start_cnv); end
    n_chk++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sv got %b exp 0", sample_valid); end
    n_chk++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", scan_done); end
    n_chk++; if ({overrun_err, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b exp 00", {overrun_err, timeout_err}); end
    n_chk++; if ({channel, sample_chan, sample_data} !== 18'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {channel, sample_chan, sample_data}); end
    for (int c = 0; c < 8; c++) begin
      rd_chan = 3'(c); #1;
      n_chk++; if (rd_data !== 12'h000) begin n_fail++; $display("FAIL reset_table[%0d] got %h exp 000", c, rd_data); end
    end
  endtask

  task automatic test_basic_scan();
    int exp_ch[$];
    clr_q(); adc_rand_lat = 0; adc_rand_data = 0; adc_lat = 5; hang_ch = -1;
    @(negedge clk); chan_mask = 8'h05; period = 16'd1000; enable = 1'b1;
    for (int i = 0; i < 4500 && sd_cyc.size() < 3; i++) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b exp 0", busy); end
    for (int s = 0; s < 3; s++) for (int c = 0; c < 8; c++) if (chan_mask[c]) exp_ch.push_back(c);
    n_chk++; if (sd_cyc.size() != 3) begin n_fail++; $display("FAIL basic_done_cnt got %0d exp 3", sd_cyc.size()); end
    n_chk++; if (st_ch.size() != exp_ch.size()) begin n_fail++; $display("FAIL basic_start_cnt got %0d exp %0d", st_ch.size(), exp_ch.size()); end
    n_chk++; if (sv_ch.size() != exp_ch.size()) begin n_fail++; $display("FAIL basic_sv_cnt got %0d exp %0d", sv_ch.size(), exp_ch.size()); end
    for (int k = 0; k < exp_ch.size() && k < st_ch.size(); k++) begin
      n_chk++; if (st_ch[k] != exp_ch[k]) begin n_fail++; $display("FAIL basic_start_ch[%0d] got %0d exp %0d", k, st_ch[k], exp_ch[k]); end
    end
    for (int k = 0; k < sv_ch.size() && k < rise_ch.size(); k++) begin
      n_chk++; if (sv_ch[k] != rise_ch[k] || sv_data[k] !== rise_data[k] || sv_cyc[k] != rise_cyc[k] + 1) begin
        n_fail++; $display("FAIL basic_sample[%0d] got ch%0d %h @%0d exp ch%0d %h @%0d", k, sv_ch[k], sv_data[k], sv_cyc[k], rise_ch[k], rise_data[k], rise_cyc[k] + 1);
      end
    end
    for (int s = 0; s < 3 && s < sd_cyc.size() && 2 * s + 1 < sv_cyc.size(); s++) begin
      n_chk++; if (sd_cyc[s] != sv_cyc[2 * s + 1] + 1) begin n_fail++; $display("FAIL basic_done_lat[%0d] got %0d exp %0d", s, sd_cyc[s], sv_cyc[2 * s + 1] + 1); end
    end
    if (st_cyc.size() >= 5) begin
      n_chk++; if (st_cyc[2] - st_cyc[0] != 1000 || st_cyc[4] - st_cyc[2] != 1000) begin
        n_fail++; $display("FAIL basic_period got %0d,%0d exp 1000", st_cyc[2] - st_cyc[0], st_cyc[4] - st_cyc[2]);
      end
    end
    rd_chan = 3'd0; #1;
    n_chk++; if (rd_data !== 12'h100) begin n_fail++; $display("FAIL basic_table0 got %h exp 100", rd_data); end
    rd_chan = 3'd2; #1;
    n_chk++; if (rd_data !== 12'h102) begin n_fail++; $display("FAIL basic_table2 got %h exp 102", rd_data); end
    rd_chan = 3'd1; #1;
    n_chk++; if (rd_data !== 12'h000) begin n_fail++; $display("FAIL basic_table1 got %h exp 000", rd_data); end
  endtask

  // Random masks, periods, latencies and data; the mask changes right after
  // the first start_cnv and must only affect the following scan.
  task automatic test_random_scans();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] m1, m2;
      int per, n1;
      int exp_ch[$];
      m1 = 8'($urandom_range(1, 255)); m2 = 8'($urandom_range(1, 255));
      per = int'($urandom_range(200, 400));
      clr_q(); adc_rand_lat = 1; adc_rand_data = 1; hang_ch = -1;
      @(negedge clk); chan_mask = m1; period = 16'(per); enable = 1'b1;
      for (int i = 0; i < per + 20 && st_ch.size() < 1; i++) @(negedge clk);
      chan_mask = m2;
      for (int i = 0; i < 2 * per + 400 && sd_cyc.size() < 2; i++) @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < 400 && busy; i++) @(negedge clk);
      n1 = 0;
      for (int c = 0; c < 8; c++) if (m1[c]) begin exp_ch.push_back(c); n1++; end
      for (int c = 0; c < 8; c++) if (m2[c]) exp_ch.push_back(c);
      n_chk++; if (sd_cyc.size() != 2 || st_ch.size() != exp_ch.size() || sv_ch.size() != exp_ch.size()) begin
        n_fail++; $display("FAIL rand%0d_counts got done%0d st%0d sv%0d exp 2/%0d/%0d", it, sd_cyc.size(), st_ch.size(), sv_ch.size(), exp_ch.size(), exp_ch.size());
      end
      for (int k = 0; k < exp_ch.size() && k < st_ch.size(); k++) begin
        n_chk++; if (st_ch[k] != exp_ch[k]) begin n_fail++; $display("FAIL rand%0d_order[%0d] got %0d exp %0d", it, k, st_ch[k], exp_ch[k]); end
      end
      for (int k = 0; k < sv_ch.size() && k < rise_ch.size(); k++) begin
        n_chk++; if (sv_ch[k] != rise_ch[k] || sv_data[k] !== rise_data[k] || sv_cyc[k] != rise_cyc[k] + 1) begin
          n_fail++; $display("FAIL rand%0d_sample[%0d] got ch%0d %h @%0d exp ch%0d %h @%0d", it, k, sv_ch[k], sv_data[k], sv_cyc[k], rise_ch[k], rise_data[k], rise_cyc[k] + 1);
        end
      end
      if (st_cyc.size() > n1) begin
        n_chk++; if (st_cyc[n1] - st_cyc[0] != per) begin n_fail++; $display("FAIL rand%0d_period got %0d exp %0d", it, st_cyc[n1] - st_cyc[0], per); end
      end
      for (int c = 0; c < 8; c++) begin
        rd_chan = 3'(c); #1;
        n_chk++; if (rd_data !== exp_tab[c]) begin n_fail++; $display("FAIL rand%0d_table[%0d] got %h exp %h", it, c, rd_data, exp_tab[c]); end
      end
    end
  endtask

  task automatic test_enable_drop();
    clr_q(); adc_rand_lat = 0; adc_lat = 20; adc_rand_data = 1; hang_ch = -1;
    @(negedge clk); chan_mask = 8'hFF; period = 16'd300; enable = 1'b1;
    for (int i = 0; i < 400 && st_ch.size() < 2; i++) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 200 && sd_cyc.size() < 1; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    n_chk++; if (st_ch.size() != 2) begin n_fail++; $display("FAIL endrop_starts got %0d exp 2", st_ch.size()); end
    n_chk++; if (sv_ch.size() != 2 || sv_ch[sv_ch.size() - 1] != 1) begin n_fail++; $display("FAIL endrop_store got n%0d exp 2 ending ch1", sv_ch.size()); end
    n_chk++; if (sd_cyc.size() != 1) begin n_fail++; $display("FAIL endrop_done got %0d exp 1", sd_cyc.size()); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop_busy got %b exp 0", busy); end
    rd_chan = 3'd1; #1;
    n_chk++; if (rd_data !== exp_tab[1]) begin n_fail++; $display("FAIL endrop_table1 got %h exp %h", rd_data, exp_tab[1]); end
  endtask

  task automatic test_overrun();
    clr_q(); adc_rand_lat = 0; adc_lat = 200; adc_rand_data = 1; hang_ch = -1;
    @(negedge clk); chan_mask = 8'h01; period = 16'd10; enable = 1'b1;
    for (int i = 0; i < 1000 && sd_cyc.size() < 2; i++) @(negedge clk);
    n_chk++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b exp 1", overrun_err); end
    n_chk++; if (sd_cyc.size() < 2 || st_cyc.size() < 2 || st_cyc[1] - sd_cyc[0] < 1 || st_cyc[1] - sd_cyc[0] > 11) begin
      n_fail++; $display("FAIL ovr_b2b got done%0d starts%0d exp next start within 11 cycles", sd_cyc.size(), st_cyc.size());
    end
    // With period 1 every busy cycle ticks, so a clear pulse always collides with a set.
    period = 16'd1;
    for (int i = 0; i < 400 && st_ch.size() < 3; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    n_chk++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b exp 1", overrun_err); end
    enable = 1'b0;
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    n_chk++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b exp 0", overrun_err); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL ovr_no_tmo got %b exp 0", timeout_err); end
  endtask

  task automatic test_timeout();
    logic [11:0] old0;
    int s, t;
    clr_q(); adc_rand_lat = 0; adc_lat = 5; adc_rand_data = 1; hang_ch = 0;
    old0 = exp_tab[0];
    @(negedge clk); chan_mask = 8'h03; period = 16'd5000; enable = 1'b1;
    for (int i = 0; i < 5100 && st_ch.size() < 1; i++) @(negedge clk);
    s = (st_cyc.size() > 0) ? st_cyc[0] : 0;
    for (int i = 0; i < 4300 && !timeout_err; i++) @(negedge clk);
    t = cyc;
    n_chk++; if (timeout_err !== 1'b1 || t < s + 4096 || t > s + 4099) begin
      n_fail++; $display("FAIL tmo_time got err=%b at +%0d exp 1 at +4096..4099", timeout_err, t - s);
    end
    for (int i = 0; i < 200 && sd_cyc.size() < 1; i++) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    hang_ch = -1;
    n_chk++; if (st_ch.size() != 2 || st_ch[st_ch.size() - 1] != 1) begin n_fail++; $display("FAIL tmo_next got n%0d exp starts ch0,ch1", st_ch.size()); end
    n_chk++; if (sv_ch.size() != 1 || sv_ch[0] != 1) begin n_fail++; $display("FAIL tmo_store got n%0d exp single ch1 sample", sv_ch.size()); end
    rd_chan = 3'd0; #1;
    n_chk++; if (rd_data !== old0) begin n_fail++; $display("FAIL tmo_table0 got %h exp %h", rd_data, old0); end
    rd_chan = 3'd1; #1;
    n_chk++; if (rd_data !== exp_tab[1]) begin n_fail++; $display("FAIL tmo_table1 got %h exp %h", rd_data, exp_tab[1]); end
    @(negedge clk); clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear got %b exp 0", timeout_err); end
  endtask

  task automatic test_reset_midscan();
    clr_q(); adc_rand_lat = 0; adc_lat = 40; adc_rand_data = 1; hang_ch = -1;
    @(negedge clk); chan_mask = 8'hFF; period = 16'd50; enable = 1'b1;
    for (int i = 0; i < 100 && st_ch.size() < 1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
    rst_n = 1'b0; #1;
    n_chk++; if ({busy, start_cnv, sample_valid, scan_done, overrun_err, timeout_err} !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_flags got %b exp 000000", {busy, start_cnv, sample_valid, scan_done, overrun_err, timeout_err});
    end
    n_chk++; if ({channel, sample_chan, sample_data} !== 18'h0) begin n_fail++; $display("FAIL rstmid_data got %h exp 0", {channel, sample_chan, sample_data}); end
    enable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n_chk++; if (sv_ch.size() != 0) begin n_fail++; $display("FAIL rstmid_no_store got %0d exp 0", sv_ch.size()); end
    for (int c = 0; c < 8; c++) begin
      rd_chan = 3'(c); #1;
      n_chk++; if (rd_data !== 12'h000) begin n_fail++; $display("FAIL rstmid_table[%0d] got %h exp 000", c, rd_data); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_random_scans();
    test_enable_drop();
    test_overrun();
    test_timeout();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter NUM_CH, default 8, number of ADC channels; channel index width is 3.
REQ-002 Parameter TIMEOUT, default 4095, maximum clk cycles allowed per conversion before abort.
REQ-003 clk  input  1  system clock; all logic updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  level; when high, the period timer runs and scans may start.
REQ-006 chan_mask  input  8  bit i set means channel i is included in the scan.
REQ-007 period  input  16  scan interval in clk cycles.
REQ-008 clear_err  input  1  one-cycle pulse that clears the sticky error flags.
REQ-009 start_cnv  output  1  one-cycle pulse to the SPI ADC master.
REQ-010 channel  output  3  ADC channel select; held stable from the start_cnv cycle until the conversion ends.
REQ-011 cnv_complete  input  1  level from the SPI master; cleared one cycle after start_cnv and set when the conversion is done.
REQ-012 result  input  12  conversion data; valid while cnv_complete is high.
REQ-013 rd_chan  input  3  read address into the result table.
REQ-014 rd_data  output  12  combinational read of table[rd_chan].
REQ-015 sample_valid  output  1  one-cycle pulse marking a new stored sample.
REQ-016 sample_chan / sample_data  output  3 / 12  channel and data of the newest sample; valid with sample_valid and held afterwards.
REQ-017 scan_done  output  1  one-cycle pulse at the end of each scan.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 overrun_err / timeout_err  output  1 / 1  sticky error flags.

Function
REQ-020 Period timer:
- Counts 0..period-1 while enable is high and generates tick when the count reaches period-1, then wraps to 0.
- period==0 or period==1 generates a tick on every cycle.
- The timer holds at 0 while enable is low.
REQ-021 FSM states are IDLE, START, WAIT_CLR, WAIT_DONE, STORE, NEXT.
REQ-022 IDLE:
- On tick with chan_mask!=0, latch chan_mask into scan_mask, select the lowest set bit as channel, and go to START.
- On tick with chan_mask==0, stay in IDLE with no outputs.
REQ-023 START asserts start_cnv for exactly one cycle, then goes to WAIT_CLR.
REQ-024 WAIT_CLR lasts one cycle and ignores cnv_complete, which may still be high from the previous conversion; then go to WAIT_DONE.
REQ-025 WAIT_DONE:
- On cnv_complete==1, go to STORE.
- If the wait counter reaches TIMEOUT, set timeout_err, skip the store, and go to NEXT.
REQ-026 STORE:
- Write result to table[channel].
- Drive sample_chan=channel and sample_data=result.
- Pulse sample_valid for 1 cycle, then go to NEXT.
REQ-027 NEXT:
- Clear the current bit in scan_mask.
- If bits remain and enable is high, select the next higher set channel and go to START.
- Otherwise pulse scan_done and go to IDLE.
REQ-028 Latency from tick to start_cnv is 1 cycle; from cnv_complete rising to sample_valid is 1 cycle; from the final STORE to scan_done is 1 cycle.
REQ-029 A tick arriving while busy is high is dropped and sets overrun_err.
REQ-030 Changes to chan_mask during a scan do not affect that scan.
REQ-031 If enable falls mid-scan, the current conversion completes and is stored, then the FSM returns to IDLE with scan_done pulsed.
REQ-032 When clear_err coincides with a new error event, the error set wins.
REQ-033 The per-conversion wait counter is 12 bits wide, resets in START, and saturates at TIMEOUT.

Reset
REQ-034 While rst_n is low:
- FSM is in IDLE, and the timer, wait counter and scan_mask are 0.
- start_cnv, sample_valid, scan_done, busy, overrun_err and timeout_err are 0.
- channel, sample_chan and sample_data are 0, and all table entries are 12'h000.
REQ-035 Reset asserted mid-scan aborts the scan immediately; no partial store occurs.

Verification
REQ-036 mask=8'h05, period=1000, ADC model returns 12'h100+ch:
- start_cnv occurs for channel 0 and then channel 2.
- table[0]=12'h100 and table[2]=12'h102.
- Two sample_valid pulses and one scan_done pulse occur per period.
REQ-037 Stale cnv_complete=1 held from the prior conversion: no STORE occurs until cnv_complete has dropped and risen again.
REQ-038 period=10 with a conversion taking 200 cycles: overrun_err=1, scans continue back-to-back, and clear_err returns the flag to 0.
REQ-039 cnv_complete is never asserted with TIMEOUT=4095: timeout_err=1 after 4095 wait cycles, the table entry is unchanged, and the next channel starts.
REQ-040 enable is dropped during the conversion of channel 1 with mask=8'hFF: channel 1 is stored, scan_done is pulsed, and no start_cnv occurs for channel 2.
REQ-041 rst_n is pulsed low in WAIT_DONE: all outputs and the table return to 0 and busy=0.
